// File: rtl/dma_word_store.sv
// dma_word_store
//   Word-addressed synchronous store used on the RAM side and on the DISK side
//   of the DMA engine. It accepts one write and/or one read per clock, and read
//   data returns one cycle later together with a valid strobe. Each word has a
//   written-flag, so a word not written since reset reads as zero. The array
//   itself is never cleared.
//
//   Optional build macro: WORD_STORE_ACCESS_COUNT_EN
//     When defined, adds saturating 32-bit wr_count/rd_count/err_count outputs.
//
// Ports:
//   clock      in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en_w       in   write request
//   en_r       in   read request
//   address    in   [ADDR_WIDTH] word address shared by read and write
//   DataIn     in   [DATA_WIDTH] write data
//   DataOut    out  [DATA_WIDTH] registered read data, holds between reads
//   read_valid out  one-cycle strobe, DataOut carries a read result
//   addr_err   out  one-cycle strobe after any request with address >= DEPTH
//   wr_count   out  [32] accepted in-range writes  (optional)
//   rd_count   out  [32] all reads                 (optional)
//   err_count  out  [32] out-of-range requests     (optional)
module dma_word_store #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 65,
   parameter int unsigned DEPTH      = 1024
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  en_w,
   input  logic                  en_r,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] DataIn,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  read_valid,
   output logic                  addr_err
`ifdef WORD_STORE_ACCESS_COUNT_EN
   ,
   output logic [31:0]           wr_count,
   output logic [31:0]           rd_count,
   output logic [31:0]           err_count
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      written;

   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic                  wr_ok;
   logic                  rd_req;
   logic                  wr_req;
   logic                  wr_oor;
   logic                  rd_oor;
   logic [DATA_WIDTH-1:0] rd_word;

   // The full address is compared, so out-of-range values never alias.
   always_comb begin
      wr_req   = (en_w == 1'b1);
      rd_req   = (en_r == 1'b1);
      in_range = (address < DEPTH_A);
      idx      = address[IDX_W-1:0];
      wr_ok    = wr_req && in_range;
      wr_oor   = wr_req && !in_range;
      rd_oor   = rd_req && !in_range;
      rd_word  = '0;
      if (in_range && written[idx])
         rd_word = mem[idx];
   end

   // Array storage has no reset; the rst_n qualifier drops a write that
   // coincides with reset being held.
   always_ff @(posedge clock) begin
      if (rst_n && wr_ok)
         mem[idx] <= DataIn;
   end

   // rd_word is sampled from the pre-edge array, which gives read-before-write
   // when a read and a write hit the same word on the same edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         written    <= '0;
         DataOut    <= '0;
         read_valid <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         if (wr_ok)
            written[idx] <= 1'b1;
         read_valid <= rd_req;
         addr_err   <= wr_oor || rd_oor;
         if (rd_req)
            DataOut <= rd_word;
      end
   end

`ifdef WORD_STORE_ACCESS_COUNT_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
      logic [32:0] s;
      s = {1'b0, a} + {31'b0, inc};
      return s[32] ? '1 : s[31:0];
   endfunction

   logic [1:0] err_inc;

   always_comb begin
      err_inc = {1'b0, wr_oor} + {1'b0, rd_oor};
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_count  <= '0;
         rd_count  <= '0;
         err_count <= '0;
      end else begin
         wr_count  <= sat_add(wr_count, {1'b0, wr_ok});
         rd_count  <= sat_add(rd_count, {1'b0, rd_req});
         err_count <= sat_add(err_count, err_inc);
      end
   end
`endif

endmodule

// File: tb/tb_dma_word_store.sv
module tb_dma_word_store;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 65;
   localparam int unsigned DEPTH = 1024;

   logic          clock = 1'b0;
   logic          rst_n;
   logic          en_w;
   logic          en_r;
   logic [AW-1:0] address;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] DataOut;
   logic          read_valid;
   logic          addr_err;
`ifdef WORD_STORE_ACCESS_COUNT_EN
   logic [31:0]   wr_count;
   logic [31:0]   rd_count;
   logic [31:0]   err_count;
`endif

   dma_word_store #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DEPTH)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .en_w      (en_w),
      .en_r      (en_r),
      .address   (address),
      .DataIn    (DataIn),
      .DataOut   (DataOut),
      .read_valid(read_valid),
      .addr_err  (addr_err)
`ifdef WORD_STORE_ACCESS_COUNT_EN
      ,
      .wr_count  (wr_count),
      .rd_count  (rd_count),
      .err_count (err_count)
`endif
   );

   always #5 clock = ~clock;

   // Reference model: a sparse map holding only words written since reset;
   // any word absent from the map reads as zero.
   logic [DW-1:0] model_mem [int];
   logic [DW-1:0] model_out;
   int unsigned   m_wr, m_rd, m_err;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_mem.delete();
      model_out = '0;
      m_wr = 0;
      m_rd = 0;
      m_err = 0;
   endtask

   task automatic chk_counters(input string tag);
`ifdef WORD_STORE_ACCESS_COUNT_EN
      chk({tag, ".wr_count"},  wr_count,  m_wr);
      chk({tag, ".rd_count"},  rd_count,  m_rd);
      chk({tag, ".err_count"}, err_count, m_err);
`else
      if (tag.len() == 0) $display("[TB] empty tag");
`endif
   endtask

   // One request issued at a negedge, sampled by the DUT on the next posedge,
   // and checked 1 time unit later.
   task automatic req(input string tag, input logic w, input logic r,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic          oor;
      logic [DW-1:0] exp_d;
      @(negedge clock);
      en_w = w; en_r = r; address = a; DataIn = d;
      oor   = (a >= AW'(DEPTH));
      exp_d = model_out;
      if (r) begin
         exp_d = '0;
         if (!oor && model_mem.exists(int'(a)))
            exp_d = model_mem[int'(a)];
         m_rd++;
      end
      if (w && !oor) begin
         model_mem[int'(a)] = d;
         m_wr++;
      end
      if (w && oor) m_err++;
      if (r && oor) m_err++;
      @(posedge clock);
      #1;
      en_w = 1'b0; en_r = 1'b0;
      chk({tag, ".data"},  DataOut, exp_d);
      chk({tag, ".valid"}, {31'b0, read_valid}, {31'b0, r});
      chk({tag, ".err"},   {31'b0, addr_err},   {31'b0, (w || r) && oor});
      model_out = exp_d;
   endtask

   task automatic do_reset(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      rst_n = 1'b0;
      en_w = w; en_r = 1'b0; address = a; DataIn = d;
      #1;
      model_reset();
      chk("rst.data",  DataOut, '0);
      chk("rst.valid", {31'b0, read_valid}, '0);
      chk("rst.err",   {31'b0, addr_err},   '0);
      @(posedge clock);
      #1;
      en_w = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      chk_counters("rst");
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          rw, rr;
      int unsigned   sel;

      rst_n = 1'b0; en_w = 1'b0; en_r = 1'b0; address = '0; DataIn = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;

      // Written word becomes unreadable after reset.
      req("pre.w5", 1'b1, 1'b0, 65'd5, 32'hDEADBEEF);
      do_reset(1'b0, '0, '0);
      req("post.r5", 1'b0, 1'b1, 65'd5, '0);

      // Write then read.
      req("wr10", 1'b1, 1'b0, 65'd10, 32'h12345678);
      req("rd10", 1'b0, 1'b1, 65'd10, '0);
      req("idle", 1'b0, 1'b0, 65'd10, '0);

      // Same-address simultaneous access.
      req("wr3",   1'b1, 1'b0, 65'd3, 32'h11);
      req("rw3",   1'b1, 1'b1, 65'd3, 32'h22);
      req("rd3",   1'b0, 1'b1, 65'd3, '0);
      req("rw4new", 1'b1, 1'b1, 65'd4, 32'h44);

      // Out of range, including no aliasing onto word 0.
      req("wr0",     1'b1, 1'b0, 65'd0, 32'h5A5A);
      req("wr1024",  1'b1, 1'b0, 65'd1024, 32'hAA);
      req("rd1024",  1'b0, 1'b1, 65'd1024, '0);
      req("rd0",     1'b0, 1'b1, 65'd0, '0);
      req("rw_hi",   1'b1, 1'b1, {1'b1, 64'd0}, 32'hBB);
      req("rd1023",  1'b0, 1'b1, 65'd1023, '0);
      req("wr1023",  1'b1, 1'b0, 65'd1023, 32'hCAFE);
      req("rd1023b", 1'b0, 1'b1, 65'd1023, '0);
      chk_counters("oor");

      // Streaming.
      for (int i = 0; i < 8; i++) req("swr", 1'b1, 1'b0, AW'(i), DW'(i + 100));
      for (int i = 0; i < 8; i++) req("srd", 1'b0, 1'b1, AW'(i), '0);

      // Reset coincident with a write to word 7.
      do_reset(1'b1, 65'd7, 32'h77);
      req("rd7", 1'b0, 1'b1, 65'd7, '0);

      // Randomised traffic, mostly around a small window and the upper edge.
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      ra = AW'($urandom_range(0, 15));
         else if (sel < 9) ra = AW'($urandom_range(DEPTH - 4, DEPTH + 3));
         else              ra = {$urandom, $urandom, $urandom};
         rd = $urandom;
         rw = ($urandom_range(0, 1) == 1);
         rr = ($urandom_range(0, 1) == 1);
         req("rnd", rw, rr, ra, rd);
      end
      chk_counters("rnd");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
